// File: rtl/au_lead_zero_seq.sv
// au_lead_zero_seq: streaming multi-word leading-zero/one counter with valid/ready in and out
module au_lead_zero_seq #(
    parameter  int WIDTH     = 8,
    parameter  int MAX_WORDS = 4,
    parameter  int ARCH      = 0,
    localparam int CW        = $clog2(WIDTH * MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_inv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_cnt,
    output logic             out_no_det,
    output logic             out_ovf
);
    localparam int LW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(MAX_WORDS + 1);

    typedef enum logic {ACC, HOLD} state_t;

    state_t            state;
    logic [CW-1:0]     acc_cnt, acc_n;
    logic [IW-1:0]     word_idx;
    logic              found, first, inv_q, ovf;
    logic              inv, fire, sat, found_n, ovf_n;
    logic [WIDTH-1:0]  d, smear, onehot;
    logic [LW-1:0]     lz;

    assign inv = first ? in_inv : inv_q;
    assign d   = in_data ^ {WIDTH{inv}};

    generate
        if (ARCH == 0) begin : g_ripple
            // smear[i] = OR of d from the MSB down to bit i, as a linear chain
            always_comb begin
                smear[WIDTH-1] = d[WIDTH-1];
                for (int i = WIDTH - 2; i >= 0; i--) smear[i] = smear[i+1] | d[i];
            end
        end else begin : g_tree
            // same smear built as a log-depth doubling prefix tree
            always_comb begin
                smear = d;
                for (int s = 1; s < WIDTH; s *= 2) smear = smear | (smear >> s);
            end
        end
    endgenerate

    assign onehot = d & ~(smear >> 1);

    // encode the one-hot leading '1' into a zero count; an all-zero word counts WIDTH
    always_comb begin
        lz = (|d) ? '0 : LW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) lz = lz | (onehot[i] ? LW'(WIDTH - 1 - i) : '0);
    end

    assign sat       = word_idx == IW'(MAX_WORDS);
    assign acc_n     = (sat || found) ? acc_cnt : acc_cnt + CW'(lz);
    assign found_n   = found | (!sat && |d);
    assign ovf_n     = ovf | sat;
    assign out_valid = state == HOLD;
    assign in_ready  = (state == ACC) || out_ready;
    assign fire      = in_valid && in_ready;

    // accumulate per accepted word; a last word publishes the result and restarts the operand
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ACC;
            out_cnt    <= '0;
            out_no_det <= 1'b0;
            out_ovf    <= 1'b0;
            acc_cnt    <= '0;
            found      <= 1'b0;
            first      <= 1'b1;
            inv_q      <= 1'b0;
            word_idx   <= '0;
            ovf        <= 1'b0;
        end else begin
            if (out_ready) state <= ACC;
            if (fire) begin
                if (in_last) begin
                    state      <= HOLD;
                    out_cnt    <= acc_n;
                    out_no_det <= !found_n;
                    out_ovf    <= ovf_n;
                    acc_cnt    <= '0;
                    found      <= 1'b0;
                    first      <= 1'b1;
                    word_idx   <= '0;
                    ovf        <= 1'b0;
                end else begin
                    acc_cnt    <= acc_n;
                    found      <= found_n;
                    ovf        <= ovf_n;
                    first      <= 1'b0;
                    inv_q      <= inv;
                    word_idx   <= sat ? word_idx : word_idx + IW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_au_lead_zero_seq.sv
// tb_au_lead_zero_seq: directed scoreboard bench for au_lead_zero_seq (WIDTH=8, MAX_WORDS=4)
module tb_au_lead_zero_seq;
    typedef struct packed {
        logic [5:0] cnt;
        logic       nd;
        logic       ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_ready, in_last, in_inv;
    logic       out_valid, out_ready, out_no_det, out_ovf;
    logic [7:0] in_data;
    logic [5:0] out_cnt;
    exp_t       q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         last_wait = 0;

    au_lead_zero_seq #(.WIDTH(8), .MAX_WORDS(4), .ARCH(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_inv(in_inv),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_cnt(out_cnt), .out_no_det(out_no_det), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // result checker: pops the oldest expected result on every output handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            n_chk++;
            assert (q.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected observed=%0d expected=queued", out_cnt);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sb_cnt", out_cnt, e.cnt);
                chk("sb_no_det", out_no_det, e.nd);
                chk("sb_ovf", out_ovf, e.ov);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l, input logic i,
                        input int c = 0, input logic nd = 1'b0, input logic ov = 1'b0);
        int k;
        in_valid = 1'b1; in_data = d; in_last = l; in_inv = i;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        last_wait = k;
        if (!in_ready) chk("in_ready_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (l) begin
            q.push_back('{cnt: 6'(c), nd: nd, ov: ov});
            chk("latency_valid", out_valid, 1);
        end
    endtask

    task automatic async_rst(input logic chk_zero);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        if (chk_zero) begin
            chk("rst_cnt", out_cnt, 0);
            chk("rst_no_det", out_no_det, 0);
            chk("rst_ovf", out_ovf, 0);
        end
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_inv = 1'b0; out_ready = 1'b1;
        #1;
        chk("reset_valid", out_valid, 0);
        chk("reset_cnt", out_cnt, 0);
        chk("reset_no_det", out_no_det, 0);
        chk("reset_ovf", out_ovf, 0);
        chk("reset_ready", in_ready, 1);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send(8'h10, 1, 0, 3, 0, 0);
        send(8'h80, 1, 0, 0, 0, 0);
        send(8'h00, 0, 0); send(8'h00, 0, 1); send(8'h05, 1, 1, 21, 0, 0);
        send(8'h00, 0, 0); send(8'h80, 0, 0); send(8'h00, 1, 0, 8, 0, 0);
        repeat (3) send(8'h00, 0, 0);
        send(8'h00, 1, 0, 32, 1, 0);
        repeat (4) send(8'h00, 0, 0);
        send(8'h00, 1, 0, 32, 1, 1);
        send(8'h01, 1, 0, 7, 0, 0);
        send(8'hFF, 0, 1); send(8'hF0, 1, 0, 12, 0, 0);
        send(8'hFF, 1, 1, 8, 1, 0);
        idle(2);
        out_ready = 1'b0;
        send(8'h03, 1, 0, 6, 0, 0);
        in_valid = 1'b1; in_data = 8'h00; in_last = 1'b1; in_inv = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_cnt", out_cnt, 6);
            chk("bp_no_det", out_no_det, 0);
            chk("bp_ovf", out_ovf, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(8'h40, 1, 0, 1, 0, 0);
        chk("tput_wait0", last_wait, 0);
        send(8'h01, 1, 0, 7, 0, 0);
        chk("tput_wait1", last_wait, 0);
        send(8'h00, 1, 0, 8, 1, 0);
        chk("tput_wait2", last_wait, 0);
        out_ready = 1'b0;
        async_rst(1'b1);
        out_ready = 1'b1;
        idle(1);
        send(8'h00, 0, 0); send(8'h00, 0, 0);
        async_rst(1'b0);
        idle(1);
        send(8'h20, 1, 0, 2, 0, 0);
        idle(3);
        chk("sb_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/au_lead_zero_seq.md
# au_lead_zero_seq

Streaming leading-zero (or leading-one) counter for operands longer than one datapath word. Operands arrive MSB-word first over a valid/ready stream. The count accumulates across words, and a registered binary count is returned over a second valid/ready stream. It sits between wide-operand sources (multi-word mantissas, big-integer units) and normalisation shifters, and reuses the combinational one-hot leading-'1' detector and encoder per word.

## Interface
- WIDTH, 8, word length of each input beat (>= 1)
- MAX_WORDS, 4, maximum counted words per operand (>= 1)
- ARCH, 0, prefix-tree architecture (0 to 2), passed to the per-word detector
- CW (localparam), clog2(WIDTH*MAX_WORDS+1), width of the count output
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset; asynchronous, active-low
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept a word
- in_data  input  WIDTH  operand word, MSB-first order across beats
- in_last  input  1  final word of the operand
- in_inv  input  1  1 = count leading ones; sampled on the first word of an operand only
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_cnt  output  CW  number of leading zeros (or ones) of the operand
- out_no_det  output  1  1 = no terminating bit found in the counted words
- out_ovf  output  1  1 = operand had more than MAX_WORDS words

## Operation
- Transfers occur when valid && ready on the same clk edge.
- Per-word detection is combinational on in_data ^ {WIDTH{inv}}:
  - inv is in_inv on the first word and the latched value afterwards.
  - The detector produces a one-hot leading-'1' position; the encoder turns it into lz in 0..WIDTH-1.
  - A zero word gives lz = WIDTH.
- Accumulator state: acc_cnt (CW bits), found, first, inv_q, word_idx (0..MAX_WORDS), ovf.
- State machine:
  - ACC: waits for words.
  - HOLD: out_valid=1, waits for out_ready.
  - ACC and HOLD can overlap. The input side always runs in ACC; HOLD is the out_valid flag.
- Per accepted word, in order:
  - If word_idx == MAX_WORDS: set ovf and ignore the word's contribution.
  - Else if !found: acc_cnt += lz, and found = (word nonzero).
  - Else (found already set): no change; the word is consumed and ignored.
  - word_idx increments, saturating at MAX_WORDS.
- On an accepted in_last:
  - out_cnt <= final acc_cnt (this word's contribution included).
  - out_no_det <= !found_final.
  - out_ovf <= ovf_final.
  - out_valid <= 1.
  - Accumulator clears (acc_cnt=0, found=0, word_idx=0, ovf=0, first=1).
- Count range: 0..WIDTH*MAX_WORDS. All-zero full operand gives WIDTH*MAX_WORDS with out_no_det=1.
- An all-zero operand shorter than MAX_WORDS gives words*WIDTH with out_no_det=1.
- in_ready = !out_valid || out_ready. It does not depend on in_valid.
- A last word arriving while the previous result is being taken updates the output in the same edge, with no bubble.
- out_valid deasserts after an out_ready handshake only if no new last word was accepted on that edge.
- Reset values:
  - out_valid=0, out_cnt=0, out_no_det=0, out_ovf=0.
  - Accumulator cleared, first=1, inv_q=0.
- Reset mid-operand discards the partial operand. The next accepted word is treated as a first word.

## Timing
- Latency: result valid on the cycle after the in_last handshake, for any operand length.
- Throughput: one word per cycle sustained, including back-to-back single-word operands.
- Under backpressure (out_valid=1, out_ready=0):
  - in_ready=0.
  - out_cnt, out_no_det and out_ovf hold stable.
  - Accumulator state holds.
- in_data, in_last and in_inv are ignored when in_valid=0 or in_ready=0.
- Critical path: detector prefix tree + encoder + CW-bit adder, within one cycle.
- All outputs except in_ready are registered.

## Test plan
All scenarios use WIDTH=8, MAX_WORDS=4.
- Single word 0x10, last, inv=0 -> next cycle out_valid=1, out_cnt=3, out_no_det=0, out_ovf=0; single word 0x80 -> out_cnt=0.
- Words 0x00, 0x00, 0x05(last) -> out_cnt=21, no_det=0; words 0x00, 0x80, 0x00(last) -> out_cnt=8 (trailing word ignored).
- Four zero words -> out_cnt=32, no_det=1, ovf=0; five zero words -> out_cnt=32, no_det=1, ovf=1; next operand 0x01(last) -> out_cnt=7, ovf=0.
- inv=1 on first word: 0xFF, 0xF0(last) -> out_cnt=12; in_inv toggled on the second word has no effect.
- Backpressure and throughput:
  - Hold out_ready=0 for 3 cycles after a result: in_ready=0 and outputs stable.
  - Then out_ready=1 with single-word operands 0x40, 0x01, 0x00 on consecutive cycles -> results 1, 7, 8(no_det=1) on consecutive cycles.
- Reset mid-operand:
  - Accept 0x00, 0x00, then assert rst_n=0 asynchronously -> out_valid=0 immediately, all outputs 0.
  - After release, 0x20(last) -> out_cnt=2.
